// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared state encoding and default width for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/fs_cell.sv
// ============================================================================
// Module      : fs_cell
// Description : One-bit full-subtractor cell computing a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & (b ^ bin)) | (b & bin);

endmodule : fs_cell

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    fs_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    // Difference bits enter at the MSB so the LSB-first result lands aligned.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Borrow  <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bor   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_bor   <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_res <= w_res_next;
                    r_bor <= w_bout;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        Diff    <= w_res_next;
                        Borrow  <= w_bout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and random self-checking bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from an idle DUT; returns to the point where the next
    // start would be accepted at edge k+WIDTH+2.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_b);
        int         cyc;
        int         busy_cnt;
        logic       held;
        logic [7:0] prev_d;
        logic       prev_b;
        prev_d = Diff;
        prev_b = Borrow;
        held   = 1'b1;
        A      = a;
        B      = b;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        A        = ~a;
        B        = ~b;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cnt++;
            if (Diff !== prev_d || Borrow !== prev_b) held = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, WIDTH);
        chk({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        chk({tag, "_hold"}, {31'd0, held}, 32'd1);
        chk({tag, "_diff"}, {24'd0, Diff}, {24'd0, exp_d});
        chk({tag, "_borrow"}, {31'd0, Borrow}, {31'd0, exp_b});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int         n_done;
        int         first_idx;
        int         last_idx;
        int         prev_idx;
        int         cyc;
        logic       gap_ok;
        logic       saw_done;
        logic [7:0] ra;
        logic [7:0] rb;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;

        #12;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_diff",   {24'd0, Diff},   32'd0);
        chk("rst_borrow", {31'd0, Borrow}, 32'd0);

        // Release between edges; first op must be accepted at the very next edge.
        @(negedge clk);
        rst_n = 1'b1;
        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("sub_00_FF", 8'h00, 8'hFF, 8'h01, 1'b1);
        run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("sub_FF_01", 8'hFF, 8'h01, 8'hFE, 1'b0);

        // Start pulsed while busy must not launch a second operation.
        A = 8'h80; B = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        A = 8'h10; B = 8'h01; start = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                n_done++;
                chk("busy_req_diff",   {24'd0, Diff},   32'h7F);
                chk("busy_req_borrow", {31'd0, Borrow}, 32'd0);
            end
            tick();
        end
        chk("busy_req_single_done", n_done, 1);

        // Start held high: one operation every WIDTH+2 cycles.
        A = 8'h09; B = 8'h04; start = 1'b1;
        tick();
        n_done    = 0;
        first_idx = -1;
        last_idx  = -1;
        prev_idx  = -1;
        gap_ok    = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (done) begin
                n_done++;
                if (first_idx < 0) first_idx = i;
                if (prev_idx >= 0 && i - prev_idx != WIDTH + 2) gap_ok = 1'b0;
                prev_idx = i;
                last_idx = i;
                chk("hold_start_diff", {24'd0, Diff}, 32'h05);
            end
            tick();
        end
        start = 1'b0;
        chk("hold_start_count", n_done, 3);
        chk("hold_start_first", first_idx, WIDTH);
        chk("hold_start_last",  last_idx, 3 * WIDTH + 4);
        chk("hold_start_gap",   {31'd0, gap_ok}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        chk("hold_start_idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset while bit 4 is in flight.
        A = 8'hAA; B = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",   {31'd0, busy},   32'd0);
        chk("async_rst_diff",   {24'd0, Diff},   32'd0);
        chk("async_rst_borrow", {31'd0, Borrow}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("async_rst_no_done", {31'd0, saw_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        chk("post_rst_quiet", {31'd0, saw_done}, 32'd0);
        run_op("sub_AA_55", 8'hAA, 8'h55, 8'h55, 1'b0);

        // Random pairs against a plain arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            ra    = 8'($urandom_range(255));
            rb    = 8'($urandom_range(255));
            A     = ra;
            B     = rb;
            start = 1'b1;
            tick();
            start = 1'b0;
            cyc   = 0;
            while (!done && cyc < 30) begin
                tick();
                cyc++;
            end
            chk("rand_latency", cyc, WIDTH);
            chk("rand_diff",   {24'd0, Diff},   {24'd0, 8'(ra - rb)});
            chk("rand_borrow", {31'd0, Borrow}, {31'd0, (ra < rb)});
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_subtractor

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  minuend, captured on the accepted start edge.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress (state SHIFT).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 SHALL have port Diff  output  WIDTH  result A-B modulo 2^WIDTH.
REQ-010 SHALL have port Borrow  output  1  final borrow-out, 1 exactly when A < B (unsigned).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-012 SHALL, in IDLE with start=1 at an edge: load A and B into shift registers, clear borrow flop, clear bit counter, go to SHIFT.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE.
REQ-014 SHALL, on each SHIFT edge: apply LSB of A-reg, LSB of B-reg, borrow flop to one bit-subtractor cell; shift cell difference into MSB of result-reg; load cell borrow-out into borrow flop; shift A-reg, B-reg right; increment counter.
REQ-015 SHALL leave SHIFT after exactly WIDTH bit edges, entering DONE on the edge processing bit WIDTH-1.
REQ-016 SHALL, on that same edge, copy the completed result-reg into Diff and the final borrow into Borrow.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE on the next edge unconditionally.
REQ-018 SHALL give latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; next start accepted at edge k+WIDTH+2.
REQ-019 SHALL ignore start in SHIFT and DONE; A and B changes outside the accepting edge have no effect.
REQ-020 SHALL hold Diff and Borrow at the last completed result from done until the next completion, including throughout a following SHIFT.
REQ-021 SHALL use a bit counter of width clog2(WIDTH+1); counter never wraps within an operation.
REQ-022 SHALL compute per cell: d = a^b^bin; bout = (~a & (b^bin)) | (b & bin).

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, Diff=0, Borrow=0, counter=0, all shift registers and borrow flop 0, regardless of clock.
REQ-024 SHALL abandon any in-flight operation on reset, without asserting done.
REQ-025 SHALL accept start at the first rising edge with rst_n high.

Structure
REQ-026 SHALL place the state enumeration and WIDTH default constant in shared package serial_sub_pkg.
REQ-027 SHALL instantiate one combinational sub-module fs_cell (ports a, b, bin, d, bout) implementing REQ-022; all sequencing stays in serial_subtractor.

Verification (WIDTH=8)
REQ-028 SHALL cover: A=0x05, B=0x03, start at edge k -> done at cycle after edge k+8, Diff=0x02, Borrow=0, busy high for 8 cycles.
REQ-029 SHALL cover: A=0x03, B=0x05 -> Diff=0xFE, Borrow=1; A=0x00, B=0xFF -> Diff=0x01, Borrow=1; A=B=0x00 -> Diff=0x00, Borrow=0.
REQ-030 SHALL cover: start pulsed with A=0x10, B=0x01 while busy of a 0x80-0x01 operation -> single done, Diff=0x7F; second request not executed.
REQ-031 SHALL cover: start held high continuously -> operations every WIDTH+2 cycles, done pulses exactly one cycle each, start ignored during DONE.
REQ-032 SHALL cover: rst_n pulled low asynchronously at bit 4 of 0xAA-0x55 -> outputs 0 immediately, no done; fresh 0xAA-0x55 after release -> Diff=0x55, Borrow=0.
REQ-033 SHALL cover: random A, B (1000 pairs) -> Diff == (A-B) mod 256 and Borrow == (A<B) at every done, checked against a reference model.
